// File: rtl/multi_signal_sync_pkg.sv
// sync_pkg: shared constants and width helpers for the multi-channel synchroniser
package sync_pkg;
  localparam int STAGES_MIN = 2;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int cnt_w(input int filt_len);
    return filt_len < 1 ? 1 : clog2(filt_len + 1);
  endfunction
endpackage

// File: rtl/multi_signal_sync_if.sv
// multi_signal_sync_if: async inputs and synchronised outputs; sticky signals exist only with SYNC_STICKY_EN
interface multi_signal_sync_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
`ifdef SYNC_STICKY_EN
  logic [WIDTH-1:0] sticky_clr;
  logic [WIDTH-1:0] change_sticky;
  modport master(output async_in, sticky_clr, input sync_out, rise_pulse, fall_pulse, change_sticky);
  modport slave(input async_in, sticky_clr, output sync_out, rise_pulse, fall_pulse, change_sticky);
`else
  modport master(output async_in, input sync_out, rise_pulse, fall_pulse);
  modport slave(input async_in, output sync_out, rise_pulse, fall_pulse);
`endif
endinterface

// File: rtl/multi_signal_sync_chan.sv
// sync_chan: one channel of flop chain, optional stability filter, edge pulses and SYNC_STICKY_EN change flag
module sync_chan
  import sync_pkg::*;
#(
  parameter int   STAGES   = 3,
  parameter int   FILT_LEN = 0,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic o,
  output logic rise,
  output logic fall
`ifdef SYNC_STICKY_EN
  ,
  input  logic clr,
  output logic sticky
`endif
);
  logic [STAGES-1:0] s;
  logic syn, filt, filt_q;
  assign syn = s[STAGES-1];
  // synchroniser chain, input enters at s[0]
  always_ff @(posedge clk)
    s <= rst ? {STAGES{RST_BIT}} : {s[STAGES-2:0], a};
  if (FILT_LEN == 0) begin : g_nf
    assign filt = syn;
  end else begin : g_f
    localparam int CW = cnt_w(FILT_LEN);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);
    logic [CW-1:0] cnt;
    logic f_r;
    // accept a new level only after it has held for FILT_LEN cycles; any return resets the count
    always_ff @(posedge clk)
      if (rst) begin
        cnt <= '0;
        f_r <= RST_BIT;
      end else if (syn == f_r) cnt <= '0;
      else if (cnt == LAST) begin
        f_r <= syn;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign filt = f_r;
  end
  // previous filtered level for edge detection
  always_ff @(posedge clk)
    filt_q <= rst ? RST_BIT : filt;
  assign o = filt;
  assign rise = filt & ~filt_q;
  assign fall = ~filt & filt_q;
`ifdef SYNC_STICKY_EN
  // change flag: a new edge beats a simultaneous clear
  always_ff @(posedge clk)
    sticky <= rst ? 1'b0 : (rise | fall) ? 1'b1 : clr ? 1'b0 : sticky;
`endif
endmodule

// File: rtl/multi_signal_sync.sv
// multi_signal_sync: WIDTH independent single-bit CDC channels; SYNC_STICKY_EN adds per-channel change flags
module multi_signal_sync
  import sync_pkg::*;
#(
  parameter int             WIDTH    = 1,
  parameter int             STAGES   = 3,
  parameter int             FILT_LEN = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input logic clk,
  input logic rst,
  multi_signal_sync_if.slave bus
);
  logic [WIDTH-1:0] so, rp, fp;
  if (STAGES < STAGES_MIN) begin : g_bad_stages
    $error("multi_signal_sync: STAGES=%0d below minimum %0d", STAGES, STAGES_MIN);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("multi_signal_sync: WIDTH must be at least 1");
  end
  if (FILT_LEN < 0) begin : g_bad_filt
    $error("multi_signal_sync: FILT_LEN must not be negative");
  end
`ifdef SYNC_STICKY_EN
  logic [WIDTH-1:0] st;
  assign bus.change_sticky = st;
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_chan #(.STAGES(STAGES), .FILT_LEN(FILT_LEN), .RST_BIT(RST_VAL[i])) u_chan (
      .clk(clk),
      .rst(rst),
      .a(bus.async_in[i]),
      .o(so[i]),
      .rise(rp[i]),
      .fall(fp[i])
`ifdef SYNC_STICKY_EN
      ,
      .clr(bus.sticky_clr[i]),
      .sticky(st[i])
`endif
    );
  end
  assign bus.sync_out = so;
  assign bus.rise_pulse = rp;
  assign bus.fall_pulse = fp;
endmodule

// File: tb/tb_multi_signal_sync.sv
// tb_multi_signal_sync: scoreboard bench over three configurations (plain, filtered, long filter with reset)
module tb_multi_signal_sync;
  typedef struct {
    int d;
    int cyc;
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] f;
  } ev_t;
  logic clk = 1'b0;
  logic rst, rst_c;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t q[$];
  logic [7:0] lvl [3] = '{8'h0A, 8'h00, 8'h01};
  multi_signal_sync_if #(.WIDTH(8)) ia ();
  multi_signal_sync_if #(.WIDTH(2)) ib ();
  multi_signal_sync_if #(.WIDTH(1)) ic ();
  multi_signal_sync #(.WIDTH(8), .STAGES(3), .FILT_LEN(0), .RST_VAL(8'h0A)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  multi_signal_sync #(.WIDTH(2), .STAGES(2), .FILT_LEN(4), .RST_VAL(2'b00)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  multi_signal_sync #(.WIDTH(1), .STAGES(2), .FILT_LEN(8), .RST_VAL(1'b1)) dut_c (.clk(clk), .rst(rst_c), .bus(ic));
  always #5 clk = ~clk;
  task automatic expect_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask
  task automatic push(input int d, input int at, input logic [7:0] s, input logic [7:0] r, input logic [7:0] f);
    q.push_back('{d, at, s, r, f});
  endtask
  task automatic chk(input int d, input logic [7:0] s, input logic [7:0] r, input logic [7:0] f);
    logic [7:0] er = '0;
    logic [7:0] ef = '0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].d == d && q[i].cyc == cyc) begin
        lvl[d] = q[i].s;
        er = q[i].r;
        ef = q[i].f;
        q.delete(i);
        break;
      end
    expect_eq($sformatf("dut%0d sync_out", d), s, lvl[d]);
    expect_eq($sformatf("dut%0d rise_pulse", d), r, er);
    expect_eq($sformatf("dut%0d fall_pulse", d), f, ef);
  endtask
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      chk(0, ia.sync_out, ia.rise_pulse, ia.fall_pulse);
      chk(1, {6'b0, ib.sync_out}, {6'b0, ib.rise_pulse}, {6'b0, ib.fall_pulse});
      chk(2, {7'b0, ic.sync_out}, {7'b0, ic.rise_pulse}, {7'b0, ic.fall_pulse});
    end
  endtask
  initial begin
    rst = 1'b1;
    rst_c = 1'b1;
    ia.async_in = 8'h0A;
    ib.async_in = 2'b00;
    ic.async_in = 1'b1;
`ifdef SYNC_STICKY_EN
    ia.sticky_clr = '0;
    ib.sticky_clr = '0;
    ic.sticky_clr = '0;
`endif
    step(3);
    rst = 1'b0;
    rst_c = 1'b0;
    step(5);
    ia.async_in = 8'h2E;
    push(0, cyc + 3, 8'h2E, 8'h24, 8'h00);
    step(5);
    ia.async_in = 8'h2A;
    push(0, cyc + 3, 8'h2A, 8'h00, 8'h04);
    step(5);
    ib.async_in = 2'b10;
    step(3);
    ib.async_in = 2'b00;
    step(10);
    ib.async_in = 2'b10;
    push(1, cyc + 6, 8'h02, 8'h02, 8'h00);
    step(8);
    ic.async_in = 1'b0;
    step(7);
    rst_c = 1'b1;
    step(2);
    rst_c = 1'b0;
    push(2, cyc + 10, 8'h00, 8'h00, 8'h01);
    step(12);
`ifdef SYNC_STICKY_EN
    expect_eq("sticky after ch2/ch5 events", ia.change_sticky, 8'h24);
    ia.sticky_clr = 8'hFF;
    step(1);
    expect_eq("sticky after clear all", ia.change_sticky, 8'h00);
    ia.sticky_clr = 8'h00;
`endif
    ia.async_in = 8'h2B;
    push(0, cyc + 3, 8'h2B, 8'h01, 8'h00);
    step(3);
`ifdef SYNC_STICKY_EN
    ia.sticky_clr = 8'h01;
    step(1);
    expect_eq("sticky set beats clear", ia.change_sticky, 8'h01);
    step(1);
    expect_eq("sticky clear alone", ia.change_sticky, 8'h00);
    ia.sticky_clr = 8'h00;
`endif
    step(4);
    expect_eq("scoreboard drained", 8'(q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
